// File: rtl/bcd_countdown.sv
// Four-digit BCD countdown timer (SS.hh) with its own hundredth-second timebase.
// Loads a saturated BCD value, counts down with borrow while running, and flags expiry.
module bcd_countdown #(
   parameter int unsigned DIV   = 500000,
   parameter int unsigned DIV_W = 19
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        strt_stp,
   output logic [15:0] digits,
   output logic        running,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state;
   logic [DIV_W-1:0]   divider;
   logic               tick;
   logic [15:0]        dec;
   logic [15:0]        load_sat;
   logic               borrow;

   assign tick = (divider == DIV_W'(DIV - 1));

   // Ripple-borrow decrement across the four decades, least significant first.
   always_comb begin
      dec    = digits;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (digits[4*i +: 4] == 4'd0) begin
               dec[4*i +: 4] = 4'd9;
            end else begin
               dec[4*i +: 4] = digits[4*i +: 4] - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
   end

   always_comb begin
      load_sat = load_val;
      for (int i = 0; i < 4; i++) begin
         if (load_val[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StIdle;
         digits  <= 16'h0000;
         divider <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else if (load) begin
         state   <= StIdle;
         digits  <= load_sat;
         divider <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (strt_stp && digits != 16'h0000) begin
                  state   <= StRun;
                  divider <= '0;
                  running <= 1'b1;
               end
            end
            StRun: begin
               if (tick) begin
                  digits <= dec;
               end
               if (tick && dec == 16'h0000) begin
                  state   <= StDone;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (strt_stp) begin
                  // Pause: divider is held, resume clears it anyway.
                  state   <= StIdle;
                  running <= 1'b0;
               end else begin
                  divider <= tick ? '0 : divider + 1'b1;
               end
            end
            StDone: begin
               state <= StDone;
            end
            default: begin
               state   <= StIdle;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: directed plan steps plus random strobes, checked every cycle
// against an integer-count reference model.
module tb_bcd_countdown;

   localparam int unsigned DIV   = 4;
   localparam int unsigned DIV_W = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0000;
   logic        strt_stp = 1'b0;
   logic [15:0] digits;
   logic        running;
   logic        done;

   int checks = 0;
   int errors = 0;

   // Reference model: count in hundredths, mode 0 idle / 1 run / 2 done, phase in cycles.
   int m_cnt  = 0;
   int m_mode = 0;
   int m_ph   = 0;

   bcd_countdown #(.DIV(DIV), .DIV_W(DIV_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .strt_stp (strt_stp),
      .digits   (digits),
      .running  (running),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'(n / 1000);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   function automatic int sat_val(input logic [15:0] v);
      int d [4];
      for (int i = 0; i < 4; i++) begin
         d[i] = int'(v[4*i +: 4]);
         if (d[i] > 9) d[i] = 9;
      end
      return d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
   endfunction

   task automatic model_step(input logic r, input logic ld, input logic [15:0] v, input logic ss);
      if (r) begin
         m_cnt = 0; m_mode = 0; m_ph = 0;
      end else if (ld) begin
         m_cnt = sat_val(v); m_mode = 0; m_ph = 0;
      end else if (m_mode == 0) begin
         if (ss && m_cnt != 0) begin
            m_mode = 1; m_ph = 0;
         end
      end else if (m_mode == 1) begin
         if (m_ph == int'(DIV) - 1) begin
            m_cnt = m_cnt - 1;
            m_ph  = 0;
            if (m_cnt == 0) m_mode = 2;
            else if (ss) m_mode = 0;
         end else if (ss) begin
            m_mode = 0;
         end else begin
            m_ph = m_ph + 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance model on the edge, compare #1 later.
   task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic ss);
      rst = r; load = ld; load_val = v; strt_stp = ss;
      @(posedge clk);
      model_step(r, ld, v, ss);
      #1;
      rst = 1'b0; load = 1'b0; strt_stp = 1'b0;
      chk("digits",  digits,          to_bcd(m_cnt));
      chk("running", 16'(running),    16'(m_mode == 1));
      chk("done",    16'(done),       16'(m_mode == 2));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      // Reset and load
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("rst_digits", digits, 16'h0000);
      chk("rst_running", 16'(running), 16'h0000);
      chk("rst_done", 16'(done), 16'h0000);
      step(1'b0, 1'b1, 16'h0003, 1'b0);
      chk("load_0003", digits, 16'h0003);

      // Countdown to zero: start at t, values at t+5, t+9, t+13
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(4);
      chk("cd_t5", digits, 16'h0002);
      idle(4);
      chk("cd_t9", digits, 16'h0001);
      idle(3);
      chk("cd_t12", digits, 16'h0001);
      idle(1);
      chk("cd_t13_digits", digits, 16'h0000);
      chk("cd_t13_done", 16'(done), 16'h0001);
      chk("cd_t13_running", 16'(running), 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(19);
      chk("done_hold", 16'(done), 16'h0001);

      // Borrow chains
      step(1'b0, 1'b1, 16'h1000, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(4);
      chk("borrow_0999", digits, 16'h0999);
      step(1'b0, 1'b1, 16'h0100, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(4);
      chk("borrow_0099", digits, 16'h0099);

      // Pause two cycles after the first tick, hold, resume
      step(1'b0, 1'b1, 16'h0500, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(4);
      chk("pause_first", digits, 16'h0499);
      idle(1);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(50);
      chk("pause_hold", digits, 16'h0499);
      chk("pause_running", 16'(running), 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(3);
      chk("resume_u4", digits, 16'h0499);
      idle(1);
      chk("resume_u5", digits, 16'h0498);

      // Priority and edge cases
      step(1'b0, 1'b1, 16'h0042, 1'b1);
      chk("prio_digits", digits, 16'h0042);
      chk("prio_running", 16'(running), 16'h0000);
      step(1'b0, 1'b1, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      chk("zero_start", 16'(running), 16'h0000);
      step(1'b0, 1'b1, 16'hFA3C, 1'b0);
      chk("sat_9939", digits, 16'h9939);

      // Reset mid-run
      step(1'b0, 1'b1, 16'h0512, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      idle(2);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("midrst_digits", digits, 16'h0000);
      chk("midrst_running", 16'(running), 16'h0000);
      chk("midrst_done", 16'(done), 16'h0000);

      // Random strobes; mostly small loads so expiry is reached often
      for (int i = 0; i < 4000; i++) begin
         logic        r, ld, ss;
         logic [15:0] v;
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 59) == 0);
         ss = ($urandom_range(0, 29) == 0);
         v  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0130));
         step(r, ld, v, ss);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
